// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that shares the register file write
// port between NUM_REQ write-back requesters. Grants are combinational and
// one-hot. The winning write is registered, so it reaches rd_* one cycle later.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_rd_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_we,
    output logic [ID_W-1:0]           grant_id,
    output logic [7:0]                busy_cnt
);

    // Per-requester views of the flat buses (the packed layout matches i*W +: W).
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_v;

    assign addr_v = req_rd_addr;
    assign data_v = req_rd_data;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win;
    logic               found;
    logic [NUM_REQ-1:0] gnt;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        if (!rst && !wb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ)
                    idx = idx - NUM_REQ;
                if (!found && req_valid[ID_W'(idx)]) begin
                    found = 1'b1;
                    win   = ID_W'(idx);
                end
            end
        end
        if (found)
            gnt[win] = 1'b1;
    end

    assign req_ready = gnt;

    // Pointer moves to the slot after the winner; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    // Register the winning write; writes to x0 are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_we    <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            grant_id <= '0;
        end else if (found) begin
            rd_we    <= (addr_v[win] != '0);
            rd_addr  <= addr_v[win];
            rd_data  <= data_v[win];
            grant_id <= win;
        end else begin
            rd_we    <= 1'b0;
        end
    end

    // Count stalled cycles (something valid, nothing granted), saturating at 255.
    always_ff @(posedge clk) begin
        if (rst)
            busy_cnt <= '0;
        else if (|req_valid && !found && busy_cnt != 8'hFF)
            busy_cnt <= busy_cnt + 8'd1;
    end

endmodule
